// File: rtl/uart_bus_bridge.sv
// UART command-frame bridge: decodes 0x57/0x52 read/write frames popped from the
// uartx2 receiver, runs one register-bus transaction, and pushes ACK/NAK (+read data).
//   state  | meaning
//   IDLE   | hunting for a command byte, discarding anything else
//   ADDRH  | waiting for address high byte
//   ADDRL  | waiting for address low byte
//   DATA   | waiting for write data (writes only)
//   CSUM   | waiting for checksum byte, then decide BUS or NAK
//   BUS    | request held on the register bus until ack or timeout
//   RESP1  | pushing ACK/NAK to the transmitter
//   RESP2  | pushing captured read data
module uart_bus_bridge #(
  parameter int RX_TIMEOUT  = 50000,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        rx_valid,
  input  logic [7:0]  rxdata,
  input  logic [7:0]  rx_status,
  output logic        read_rx,
  input  logic        tx_empty,
  output logic [7:0]  txdata,
  output logic        write_tx,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_write,
  output logic        bus_read,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int RXW = $clog2(RX_TIMEOUT + 1);
  localparam int BTW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDRH, S_ADDRL, S_DATA, S_CSUM, S_BUS, S_RESP1, S_RESP2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_cmd_wr, w_cmd_wr_nxt;
  logic [7:0]       r_sum, w_sum_nxt;
  logic             r_bad, w_bad_nxt;
  logic [RXW-1:0]   r_rx_tmr, w_rx_tmr_nxt;
  logic [BTW-1:0]   r_bus_tmr, w_bus_tmr_nxt;
  logic [7:0]       r_resp, w_resp_nxt;
  logic [7:0]       r_rdata, w_rdata_nxt;
  logic             r_rd_ok, w_rd_ok_nxt;
  logic             r_read_rx, w_read_rx_nxt;
  logic             r_write_tx, w_write_tx_nxt;
  logic [7:0]       r_txdata, w_txdata_nxt;
  logic [15:0]      r_bus_addr, w_addr_nxt;
  logic [7:0]       r_bus_wdata, w_wdata_nxt;
  logic             r_bus_write, w_bus_write_nxt;
  logic             r_bus_read, w_bus_read_nxt;
  logic             r_busy, w_busy_nxt;
  logic [7:0]       r_err_count, w_err_nxt;

  logic             w_pop;
  logic             w_rx_err;
  logic [7:0]       w_sum_add;
  logic             w_unused_status;

  // read_rx high blocks a second pop of the byte the UART has not yet retired
  assign w_pop           = rx_valid && !r_read_rx;
  assign w_rx_err        = rx_status[3] | rx_status[4];
  assign w_sum_add       = r_sum + rxdata;
  assign w_unused_status = ^{rx_status[7:5], rx_status[2:0]};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_cmd_wr    <= 1'b0;
      r_sum       <= '0;
      r_bad       <= 1'b0;
      r_rx_tmr    <= '0;
      r_bus_tmr   <= '0;
      r_resp      <= '0;
      r_rdata     <= '0;
      r_rd_ok     <= 1'b0;
      r_read_rx   <= 1'b0;
      r_write_tx  <= 1'b0;
      r_txdata    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_write <= 1'b0;
      r_bus_read  <= 1'b0;
      r_busy      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_wr    <= w_cmd_wr_nxt;
      r_sum       <= w_sum_nxt;
      r_bad       <= w_bad_nxt;
      r_rx_tmr    <= w_rx_tmr_nxt;
      r_bus_tmr   <= w_bus_tmr_nxt;
      r_resp      <= w_resp_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rd_ok     <= w_rd_ok_nxt;
      r_read_rx   <= w_read_rx_nxt;
      r_write_tx  <= w_write_tx_nxt;
      r_txdata    <= w_txdata_nxt;
      r_bus_addr  <= w_addr_nxt;
      r_bus_wdata <= w_wdata_nxt;
      r_bus_write <= w_bus_write_nxt;
      r_bus_read  <= w_bus_read_nxt;
      r_busy      <= w_busy_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_wr_nxt    = r_cmd_wr;
    w_sum_nxt       = r_sum;
    w_bad_nxt       = r_bad;
    w_rx_tmr_nxt    = r_rx_tmr;
    w_bus_tmr_nxt   = r_bus_tmr;
    w_resp_nxt      = r_resp;
    w_rdata_nxt     = r_rdata;
    w_rd_ok_nxt     = r_rd_ok;
    w_read_rx_nxt   = 1'b0;
    w_write_tx_nxt  = 1'b0;
    w_txdata_nxt    = r_txdata;
    w_addr_nxt      = r_bus_addr;
    w_wdata_nxt     = r_bus_wdata;
    w_bus_write_nxt = r_bus_write;
    w_bus_read_nxt  = r_bus_read;
    w_err_nxt       = r_err_count;

    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_read_rx_nxt = 1'b1;
          w_rx_tmr_nxt  = RXW'(RX_TIMEOUT - 1);
          if (rxdata == CMD_WR || rxdata == CMD_RD) begin
            w_cmd_wr_nxt = (rxdata == CMD_WR);
            w_sum_nxt    = rxdata;
            w_bad_nxt    = 1'b0;
            w_state_nxt  = S_ADDRH;
          end
        end
      end
      S_ADDRH, S_ADDRL, S_DATA, S_CSUM: begin
        if (w_pop) begin
          w_read_rx_nxt = 1'b1;
          w_sum_nxt     = w_sum_add;
          w_bad_nxt     = r_bad | w_rx_err;
          w_rx_tmr_nxt  = RXW'(RX_TIMEOUT - 1);
          case (r_state)
            S_ADDRH: begin
              w_addr_nxt[15:8] = rxdata;
              w_state_nxt      = S_ADDRL;
            end
            S_ADDRL: begin
              w_addr_nxt[7:0] = rxdata;
              w_state_nxt     = r_cmd_wr ? S_DATA : S_CSUM;
            end
            S_DATA: begin
              w_wdata_nxt = rxdata;
              w_state_nxt = S_CSUM;
            end
            default: begin
              if (w_sum_add != 8'h00 || r_bad || w_rx_err) begin
                w_resp_nxt  = NAK;
                w_rd_ok_nxt = 1'b0;
                w_state_nxt = S_RESP1;
              end else begin
                w_bus_write_nxt = r_cmd_wr;
                w_bus_read_nxt  = !r_cmd_wr;
                w_bus_tmr_nxt   = BTW'(BUS_TIMEOUT - 1);
                w_state_nxt     = S_BUS;
              end
            end
          endcase
        end else if (r_rx_tmr == '0) begin
          // stalled frame is abandoned without any response
          w_state_nxt = S_IDLE;
        end else begin
          w_rx_tmr_nxt = r_rx_tmr - RXW'(1);
        end
      end
      S_BUS: begin
        // ack is checked first so it wins a tie with the final timeout cycle
        if (bus_ack) begin
          w_bus_write_nxt = 1'b0;
          w_bus_read_nxt  = 1'b0;
          w_resp_nxt      = ACK;
          w_rd_ok_nxt     = !r_cmd_wr;
          if (!r_cmd_wr) w_rdata_nxt = bus_rdata;
          w_state_nxt     = S_RESP1;
        end else if (r_bus_tmr == '0) begin
          w_bus_write_nxt = 1'b0;
          w_bus_read_nxt  = 1'b0;
          w_resp_nxt      = NAK;
          w_rd_ok_nxt     = 1'b0;
          w_state_nxt     = S_RESP1;
        end else begin
          w_bus_tmr_nxt = r_bus_tmr - BTW'(1);
        end
      end
      S_RESP1: begin
        if (tx_empty && !r_write_tx) begin
          w_write_tx_nxt = 1'b1;
          w_txdata_nxt   = r_resp;
          if (r_resp == NAK && r_err_count != 8'hFF) w_err_nxt = r_err_count + 8'd1;
          w_state_nxt    = r_rd_ok ? S_RESP2 : S_IDLE;
        end
      end
      S_RESP2: begin
        // write_tx still high on the cycle after RESP1's push spaces the pushes 2 cycles apart
        if (tx_empty && !r_write_tx) begin
          w_write_tx_nxt = 1'b1;
          w_txdata_nxt   = r_rdata;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign read_rx   = r_read_rx;
  assign write_tx  = r_write_tx;
  assign txdata    = r_txdata;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_write = r_bus_write;
  assign bus_read  = r_bus_read;
  assign busy      = r_busy;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: models the UART RX queue, TX acceptance and a bus
// responder, then compares per-frame outcomes against vector tables and a frame-level model.
module tb_uart_bus_bridge;
  localparam int RXT = 300;
  localparam int BT  = 255;

  logic        clk = 1'b0;
  logic        nreset;
  logic        rx_valid, read_rx, tx_empty, write_tx;
  logic [7:0]  rxdata, rx_status, txdata, bus_wdata, bus_rdata, err_count;
  logic [15:0] bus_addr;
  logic        bus_write, bus_read, bus_ack, busy;

  uart_bus_bridge #(.RX_TIMEOUT(RXT), .BUS_TIMEOUT(BT)) dut (
    .clk(clk), .nreset(nreset),
    .rx_valid(rx_valid), .rxdata(rxdata), .rx_status(rx_status), .read_rx(read_rx),
    .tx_empty(tx_empty), .txdata(txdata), .write_tx(write_tx),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rxq[$];
  logic [7:0]  txq[$];
  int          bus_n = 0, bus_hi = 0;
  logic        bus_wr_cap;
  logic [15:0] bus_addr_cap;
  logic [7:0]  bus_wdata_cap;
  int          rx_viol = 0, tx_viol = 0, bus_viol = 0;
  int          cfg_dly = -1;
  logic [7:0]  cfg_rdata = 8'h00;
  int          cycle = 0, last_push = -10, tx_busy = 0;
  bit          prev_rr = 1'b0, req_act = 1'b0, edge_txe;
  int          exp_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment: UART RX/TX behaviour and bus responder, all sampled 1 time unit after the edge
  initial begin
    rx_valid = 0; rxdata = 0; rx_status = 0; tx_empty = 1; bus_ack = 0; bus_rdata = 0;
    forever begin
      @(posedge clk); #1;
      cycle++;
      edge_txe = tx_empty;
      if (read_rx) begin
        if (rxq.size() > 0) void'(rxq.pop_front()); else rx_viol++;
        if (prev_rr) rx_viol++;
      end
      prev_rr = read_rx;
      if (write_tx) begin
        txq.push_back(txdata);
        if (!edge_txe) tx_viol++;
        if (cycle - last_push < 2) tx_viol++;
        last_push = cycle;
        tx_busy = 2 + $urandom_range(0, 3);
      end
      if (tx_busy > 0) begin tx_busy--; tx_empty = 1'b0; end
      else tx_empty = ($urandom_range(0, 3) != 0);
      if (bus_write && bus_read) bus_viol++;
      if (bus_write || bus_read) begin
        if (!req_act) begin
          req_act = 1'b1; bus_hi = 0; bus_n++;
          bus_wr_cap = bus_write; bus_addr_cap = bus_addr; bus_wdata_cap = bus_wdata;
        end else if (bus_addr != bus_addr_cap || bus_wdata != bus_wdata_cap || bus_write != bus_wr_cap)
          bus_viol++;
        bus_hi++;
        if (bus_hi - 1 == cfg_dly) begin bus_ack = 1'b1; bus_rdata = cfg_rdata; end
        else begin bus_ack = 1'b0; bus_rdata = 8'($urandom); end
      end else begin
        req_act = 1'b0; bus_ack = 1'b0;
      end
      rx_valid = (rxq.size() > 0) && ($urandom_range(0, 3) != 0);
      if (rxq.size() > 0) {rx_status, rxdata} = rxq[0];
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic feed(input logic [39:0] b, input int len, input int eidx, input logic [7:0] est);
    logic [7:0] st;
    for (int i = 0; i < len; i++) begin
      st = (i == eidx) ? est : (8'($urandom) & 8'hE7);
      rxq.push_back({st, b[39-8*i -: 8]});
    end
  endtask

  task automatic wait_done(input string name);
    int stable;
    int n;
    stable = 0; n = 0;
    while (stable < 3 && n < 3000) begin
      @(posedge clk); #2; n++;
      if (rxq.size() == 0 && !busy && !read_rx) stable++; else stable = 0;
    end
    check({name, "_done"}, stable, 3);
  endtask

  task automatic clear_logs();
    txq.delete();
    bus_n = 0;
  endtask

  task automatic expect_result(input string name, input bit ereq, input bit ewr,
                               input logic [15:0] eaddr, input logic [7:0] ewd, input int ehi,
                               input int entx, input logic [7:0] tx0, input logic [7:0] tx1);
    check({name, "_reqs"}, bus_n, ereq);
    if (ereq && bus_n > 0) begin
      check({name, "_wr"}, bus_wr_cap, ewr);
      check({name, "_addr"}, bus_addr_cap, eaddr);
      if (ewr) check({name, "_wdata"}, bus_wdata_cap, ewd);
      check({name, "_req_cycles"}, bus_hi, ehi);
    end
    check({name, "_ntx"}, txq.size(), entx);
    if (txq.size() > 0) check({name, "_tx0"}, txq[0], tx0);
    if (entx > 1 && txq.size() > 1) check({name, "_tx1"}, txq[1], tx1);
    if (tx0 == 8'h15 && exp_err < 255) exp_err++;
    check({name, "_err_count"}, err_count, exp_err);
    check({name, "_busy"}, busy, 0);
    check({name, "_req_idle"}, bus_write | bus_read, 0);
  endtask

  // Frame-level reference: sum rule, status rule, ack-vs-timeout rule
  task automatic run_random(input int n);
    logic [7:0]  fb[5];
    logic [7:0]  cmd, d, cs, g, tot, rd, est;
    logic [15:0] addr;
    bit          wr, ok, acked;
    int          len, eidx, dly, ng;
    for (int k = 0; k < n; k++) begin
      wr = ($urandom_range(0, 1) == 1);
      addr = 16'($urandom); d = 8'($urandom); rd = 8'($urandom);
      cmd = wr ? 8'h57 : 8'h52;
      len = wr ? 5 : 4;
      cs = 8'h00 - (cmd + addr[15:8] + addr[7:0] + (wr ? d : 8'h00));
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      fb[0] = cmd; fb[1] = addr[15:8]; fb[2] = addr[7:0];
      fb[3] = wr ? d : cs; fb[4] = wr ? cs : 8'h00;
      eidx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
      est = ($urandom_range(0, 1) == 1) ? 8'h08 : 8'h10;
      dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
      clear_logs();
      cfg_dly = dly; cfg_rdata = rd;
      ng = $urandom_range(0, 2);
      for (int j = 0; j < ng; j++) begin
        g = 8'($urandom);
        if (g == 8'h57 || g == 8'h52) g = 8'h00;
        rxq.push_back({8'($urandom), g});
      end
      feed({fb[0], fb[1], fb[2], fb[3], fb[4]}, len, eidx, est);
      tot = 8'h00;
      for (int j = 0; j < len; j++) tot = tot + fb[j];
      ok = (tot == 8'h00) && !(eidx >= 1);
      acked = ok && dly >= 0 && dly < BT;
      wait_done($sformatf("rnd%0d", k));
      expect_result($sformatf("rnd%0d", k), ok, wr, addr, d,
                    (dly >= 0 && dly < BT) ? dly + 1 : BT,
                    (acked && !wr) ? 2 : 1, acked ? 8'h06 : 8'h15, rd);
    end
  endtask

  typedef struct {
    logic [39:0] b; int len; int eidx; logic [7:0] est; int dly; logic [7:0] rdata;
    bit req; bit wr; logic [15:0] addr; logic [7:0] wd; int hi; int ntx;
    logic [7:0] tx0; logic [7:0] tx1;
  } vec_t;
  vec_t vt[11];

  int w;

  initial begin
    // 57 12 34 A5 sums to 0x42, so the passing checksum is 0xBE; 0xC4 must be NAKed
    vt[0]  = '{40'h571234A5BE, 5, -1, 8'h00,   3, 8'h00, 1'b1, 1'b1, 16'h1234, 8'hA5,   4, 1, 8'h06, 8'h00};
    vt[1]  = '{40'h5200109E00, 4, -1, 8'h00,   2, 8'h5A, 1'b1, 1'b0, 16'h0010, 8'h00,   3, 2, 8'h06, 8'h5A};
    vt[2]  = '{40'h570001FF00, 5, -1, 8'h00,   3, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,   0, 1, 8'h15, 8'h00};
    vt[3]  = '{40'h571234A5BE, 5,  2, 8'h10,   3, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,   0, 1, 8'h15, 8'h00};
    vt[4]  = '{40'h571234A5C4, 5, -1, 8'h00,   3, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,   0, 1, 8'h15, 8'h00};
    vt[5]  = '{40'h52ABCD3600, 4, -1, 8'h00,   0, 8'hC3, 1'b1, 1'b0, 16'hABCD, 8'h00,   1, 2, 8'h06, 8'hC3};
    vt[6]  = '{40'h5200109E00, 4, -1, 8'h00,  -1, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h00, 255, 1, 8'h15, 8'h00};
    vt[7]  = '{40'h57FFFF00AB, 5,  4, 8'h08,   1, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,   0, 1, 8'h15, 8'h00};
    vt[8]  = '{40'h5200109E00, 4, -1, 8'h00, 254, 8'h11, 1'b1, 1'b0, 16'h0010, 8'h00, 255, 2, 8'h06, 8'h11};
    vt[9]  = '{40'h57000000A9, 5, -1, 8'h00,   1, 8'h00, 1'b1, 1'b1, 16'h0000, 8'h00,   2, 1, 8'h06, 8'h00};
    vt[10] = '{40'h57000000A9, 5,  0, 8'h18,   1, 8'h00, 1'b1, 1'b1, 16'h0000, 8'h00,   2, 1, 8'h06, 8'h00};

    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_read_rx", read_rx, 0);
    check("rst_write_tx", write_tx, 0);
    check("rst_bus_write", bus_write, 0);
    check("rst_bus_read", bus_read, 0);
    check("rst_busy", busy, 0);
    check("rst_txdata", txdata, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_err_count", err_count, 0);
    #1 nreset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      clear_logs();
      cfg_dly = vt[i].dly; cfg_rdata = vt[i].rdata;
      feed(vt[i].b, vt[i].len, vt[i].eidx, vt[i].est);
      wait_done($sformatf("vec%0d", i));
      expect_result($sformatf("vec%0d", i), vt[i].req, vt[i].wr, vt[i].addr, vt[i].wd,
                    vt[i].hi, vt[i].ntx, vt[i].tx0, vt[i].tx1);
    end

    // Garbage then a stalled frame: must time out silently
    clear_logs();
    feed(40'h00FF570000, 4, -1, 8'h00);
    w = 0;
    while (rxq.size() > 0 && w < 200) begin @(posedge clk); #2; w++; end
    check("to_rx_drained", rxq.size(), 0);
    repeat (5) @(posedge clk); #2;
    check("to_busy_mid", busy, 1);
    repeat (RXT - 20) @(posedge clk); #2;
    check("to_busy_before", busy, 1);
    repeat (30) @(posedge clk); #2;
    check("to_busy_after", busy, 0);
    check("to_ntx", txq.size(), 0);
    check("to_reqs", bus_n, 0);
    check("to_err_count", err_count, exp_err);
    clear_logs();
    cfg_dly = vt[0].dly;
    feed(vt[0].b, vt[0].len, -1, 8'h00);
    wait_done("to_follow");
    expect_result("to_follow", 1'b1, 1'b1, 16'h1234, 8'hA5, 4, 1, 8'h06, 8'h00);

    run_random(40);

    for (int i = 0; i < 300; i++) begin
      clear_logs();
      feed(40'h570001FF00, 5, -1, 8'h00);
      wait_done($sformatf("sat%0d", i));
      expect_result($sformatf("sat%0d", i), 1'b0, 1'b0, 16'h0, 8'h0, 0, 1, 8'h15, 8'h00);
    end
    check("sat_final", err_count, 8'hFF);

    // Reset in the middle of a stalled read
    clear_logs();
    cfg_dly = -1;
    feed(40'h5200109E00, 4, -1, 8'h00);
    w = 0;
    while (!bus_read && w < 200) begin @(posedge clk); #2; w++; end
    check("mr_bus_read_up", bus_read, 1);
    repeat (20) @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check("mr_bus_read_drop", bus_read, 0);
    check("mr_busy_drop", busy, 0);
    check("mr_err_clear", err_count, 0);
    exp_err = 0;
    repeat (2) @(posedge clk);
    #3 nreset = 1'b1;
    repeat (30) @(posedge clk); #2;
    check("mr_ntx", txq.size(), 0);
    check("mr_bus_read_idle", bus_read, 0);
    clear_logs();
    cfg_dly = vt[1].dly; cfg_rdata = vt[1].rdata;
    feed(vt[1].b, vt[1].len, -1, 8'h00);
    wait_done("mr_follow");
    expect_result("mr_follow", 1'b1, 1'b0, 16'h0010, 8'h00, 3, 2, 8'h06, 8'h5A);

    check("rx_protocol", rx_viol, 0);
    check("tx_protocol", tx_viol, 0);
    check("bus_protocol", bus_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
